ds_sample_uart_tx: RTL and testbench
====================================

DS_SAMPLE_UART_TX -- requirements
Module: ds_sample_uart_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one decimated sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, sample buffer depth (power of 2).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per UART bit (1 MHz clk -> 125 kbaud).
REQ-004 SHALL have parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port din  input  DATA_W  decimated sample, connected to the fir_out output of the decimation chain.
REQ-008 SHALL have port din_valid  input  1  one-cycle strobe qualifying din, connected to fir_valid.
REQ-009 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in transmission.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  samples currently buffered.
REQ-012 SHALL have port overflow  output  1  sticky flag: a sample was dropped.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-014 SHALL write din into the FIFO on each cycle din_valid=1 and the FIFO is not full; no ready/backpressure exists.
REQ-015 SHALL drop din when din_valid=1 and fifo_level=FIFO_DEPTH with no pop in the same cycle, and set overflow=1 on the next edge.
REQ-016 SHALL accept a write into a full FIFO when a pop occurs in the same cycle; fifo_level stays FIFO_DEPTH.
REQ-017 SHALL transmit each sample as one 5-byte frame: SYNC_BYTE, then din[31:24], [23:16], [15:8], [7:0].
REQ-018 SHALL send each byte as start bit 0, 8 data bits LSB-first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-019 SHALL implement FSM states IDLE, START, DATA, STOP, with a byte index 0..4 and a bit index 0..7.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop one sample and move to START on the next edge; tx drives 0 from that edge.
REQ-021 SHALL move START->DATA after CLKS_PER_BIT cycles, DATA->STOP after 8 bits, and STOP->START for byte index<4.
REQ-022 SHALL move STOP->IDLE after the stop bit of byte index 4 and pulse frame_done=1 on that transition cycle.
REQ-023 SHALL spend exactly one cycle in IDLE between back-to-back frames (tx=1); frame period = 50*CLKS_PER_BIT+1 cycles.
REQ-024 SHALL give latency of 2 edges from din_valid (empty FIFO, IDLE) to the tx falling edge: write edge, then pop edge.
REQ-025 SHALL assert busy from the pop edge until the IDLE return; busy=0 in IDLE.
REQ-026 SHALL treat din as raw two's-complement bits; no scaling, rounding or sign handling.
REQ-027 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH using one extra pointer bit to distinguish full from empty.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, set tx=1, busy=0, fifo_level=0, overflow=0, frame_done=0, FSM=IDLE, and all counters to 0.
REQ-029 SHALL abort a frame in progress when reset is asserted mid-frame, discarding the partial frame and all buffered samples.
REQ-030 SHALL clear overflow only by reset.

Structure
REQ-031 SHALL place DATA_W, SYNC_BYTE, default CLKS_PER_BIT and the FSM state enumeration in shared package ds_pkg.
REQ-032 SHALL implement the buffer as sub-module ds_sync_fifo (push, pop, full, empty, level), instantiated once.

Verification
REQ-033 SHALL cover single sample: din=32'h12345678 pulsed once -> tx bytes A5,12,34,56,78, frame_done after 400 cycles, busy low afterwards.
REQ-034 SHALL cover back-to-back: 3 samples on consecutive cycles -> 3 frames, 1-cycle tx-high gap each, fifo_level 2 -> 1 -> 0.
REQ-035 SHALL cover overflow: 10 samples in 10 cycles with FIFO_DEPTH=8 -> first 9 transmitted (1 popped + 8 buffered), 10th dropped, overflow=1 held.
REQ-036 SHALL cover full-plus-pop: a write in the pop cycle with level=8 -> accepted, level stays 8, overflow stays 0.
REQ-037 SHALL cover reset mid-frame: reset during byte 2 -> tx=1 next edge, level=0, overflow=0; a new sample then starts a clean frame with A5.
REQ-038 SHALL cover the negative sample 32'hFFFFFFFE -> bytes A5,FF,FF,FF,FE, bit timing checked at CLKS_PER_BIT=8 and 16.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared constants, FSM state type and frame byte selection for the sample UART transmitter.
package ds_pkg;

  localparam int         DATA_W       = 32;
  localparam int         CLKS_PER_BIT = 8;
  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         FRAME_BYTES  = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Byte 0 is the sync header, bytes 1..4 are the sample MSB first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [31:0] word,
                                            input logic [7:0]  sync);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ds_sync_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module ds_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);

  // Pointer update; reset discards all buffered samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ds_sample_uart_tx.sv
// Buffers decimated samples and sends each as a 5-byte 8N1 UART frame: sync byte then sample MSB first.
module ds_sample_uart_tx #(
  parameter int         DATA_W       = ds_pkg::DATA_W,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         CLKS_PER_BIT = ds_pkg::CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = ds_pkg::SYNC_BYTE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  import ds_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t         state, state_next;
  logic [CW-1:0]     clk_cnt, clk_cnt_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [2:0]        byte_idx, byte_idx_next;
  logic [31:0]       word, word_next;
  logic [DATA_W-1:0] fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              bit_end;
  logic [7:0]        cur_byte;

  ds_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (din_valid),
    .pop     (pop),
    .wr_data (din),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign cur_byte = frame_byte(byte_idx, word, SYNC_BYTE);

  // State, counters and the latched sample; overflow sticks until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      clk_cnt  <= clk_cnt_next;
      bit_idx  <= bit_idx_next;
      byte_idx <= byte_idx_next;
      word     <= word_next;
      if (din_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Next-state, bit timing and line drive.
  always_comb begin
    state_next    = state;
    clk_cnt_next  = clk_cnt;
    bit_idx_next  = bit_idx;
    byte_idx_next = byte_idx;
    word_next     = word;
    pop           = 1'b0;
    frame_done    = 1'b0;
    tx            = 1'b1;
    busy          = (state != IDLE);

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          word_next     = 32'(fifo_rd);
          state_next    = START;
          clk_cnt_next  = '0;
          bit_idx_next  = '0;
          byte_idx_next = '0;
        end
      end

      START: begin
        tx = 1'b0;
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      DATA: begin
        tx = cur_byte[bit_idx];
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          clk_cnt_next = '0;
          if (byte_idx == 3'(FRAME_BYTES - 1)) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end else begin
            byte_idx_next = byte_idx + 3'd1;
            state_next    = START;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ds_sample_uart_tx.sv
// Directed bench for ds_sample_uart_tx: frame content, bit timing, FIFO level/overflow and reset behaviour.
module tb_ds_sample_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;

  logic       tx8, busy8, ovf8, fd8;
  logic [3:0] lvl8;
  logic       tx16, busy16, ovf16, fd16;
  logic [3:0] lvl16;

  int asserts = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ds_sample_uart_tx #(
    .DATA_W       (32),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (8),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .tx         (tx8),
    .busy       (busy8),
    .fifo_level (lvl8),
    .overflow   (ovf8),
    .frame_done (fd8)
  );

  ds_sample_uart_tx #(
    .DATA_W       (32),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (16),
    .SYNC_BYTE    (8'hA5)
  ) dut16 (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .tx         (tx16),
    .busy       (busy16),
    .fifo_level (lvl16),
    .overflow   (ovf16),
    .frame_done (fd16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_start(input bit sel, input int limit, output bit found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      if ((sel ? tx16 : tx8) === 1'b0) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
  endtask

  // Called on the first start-bit cycle; samples every cycle of the 5-byte frame.
  task automatic rx_frame(input bit sel, output logic [39:0] bytes, output int glitches, output int fd_errs);
    int   cpb;
    logic v, fd, held, last;
    cpb = sel ? 16 : 8;
    bytes = '0;
    glitches = 0;
    fd_errs = 0;
    held = 1'b1;
    for (int by = 0; by < 5; by++)
      for (int bi = 0; bi < 10; bi++)
        for (int c = 0; c < cpb; c++) begin
          v  = sel ? tx16 : tx8;
          fd = sel ? fd16 : fd8;
          if (c == 0) begin
            held = v;
            if (bi == 0 && v !== 1'b0) glitches++;
            if (bi == 9 && v !== 1'b1) glitches++;
            if (bi >= 1 && bi <= 8) bytes[(4 - by) * 8 + (bi - 1)] = v;
          end else if (v !== held) begin
            glitches++;
          end
          last = (by == 4 && bi == 9 && c == cpb - 1);
          if (fd !== last) fd_errs++;
          step();
        end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din = 32'hFFFF_FFFF;
    din_valid = 1'b1;
    step();
    step();
    asserts++; if (tx8 !== 1'b1)   begin failures++; $display("FAIL reset_tx: got %b expected 1", tx8); end
    asserts++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    asserts++; if (lvl8 !== 4'd0)  begin failures++; $display("FAIL reset_level: got %0d expected 0", lvl8); end
    asserts++; if (ovf8 !== 1'b0)  begin failures++; $display("FAIL reset_overflow: got %b expected 0", ovf8); end
    asserts++; if (fd8 !== 1'b0)   begin failures++; $display("FAIL reset_frame_done: got %b expected 0", fd8); end
    asserts++; if (tx16 !== 1'b1)  begin failures++; $display("FAIL reset_tx16: got %b expected 1", tx16); end
    din_valid = 1'b0;
    reset = 1'b0;
    step();
    asserts++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("FAIL reset_idle: tx %b busy %b expected 1 0", tx8, busy8); end
  endtask

  task automatic test_single();
    logic [39:0] got;
    int gl, fe;
    apply_reset();
    din = 32'h1234_5678;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    asserts++; if (tx8 !== 1'b1 || lvl8 !== 4'd1) begin failures++; $display("FAIL single_after_write: tx %b level %0d expected 1 1", tx8, lvl8); end
    step();
    asserts++; if (tx8 !== 1'b0 || busy8 !== 1'b1 || lvl8 !== 4'd0) begin
      failures++; $display("FAIL single_after_pop: tx %b busy %b level %0d expected 0 1 0", tx8, busy8, lvl8);
    end
    rx_frame(1'b0, got, gl, fe);
    asserts++; if (got !== 40'hA5_1234_5678) begin failures++; $display("FAIL single_bytes: got %h expected a512345678", got); end
    asserts++; if (gl !== 0) begin failures++; $display("FAIL single_timing: got %0d bit errors expected 0", gl); end
    asserts++; if (fe !== 0) begin failures++; $display("FAIL single_frame_done: got %0d misplaced cycles expected 0", fe); end
    asserts++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("FAIL single_end_idle: tx %b busy %b expected 1 0", tx8, busy8); end
  endtask

  task automatic test_back_to_back();
    logic [2:0][31:0] w;
    logic [39:0] got;
    int gl, fe;
    w[0] = 32'hDEAD_BEEF;
    w[1] = 32'h0000_0001;
    w[2] = 32'h8000_0000;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          din = w[i];
          din_valid = 1'b1;
          step();
        end
        din_valid = 1'b0;
        asserts++; if (lvl8 !== 4'd2) begin failures++; $display("FAIL b2b_level_full: got %0d expected 2", lvl8); end
      end
      begin
        step();
        step();
        for (int k = 0; k < 3; k++) begin
          if (k > 0) begin
            asserts++; if (tx8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("FAIL b2b_gap_%0d: tx %b busy %b expected 1 0", k, tx8, busy8); end
            step();
            asserts++; if (lvl8 !== 4'(2 - k)) begin failures++; $display("FAIL b2b_level_%0d: got %0d expected %0d", k, lvl8, 2 - k); end
          end
          asserts++; if (tx8 !== 1'b0) begin failures++; $display("FAIL b2b_start_%0d: tx %b expected 0", k, tx8); end
          rx_frame(1'b0, got, gl, fe);
          asserts++; if (got !== {8'hA5, w[k]} || gl !== 0 || fe !== 0) begin
            failures++; $display("FAIL b2b_frame_%0d: got %h errs %0d/%0d expected %h errs 0/0", k, got, gl, fe, {8'hA5, w[k]});
          end
        end
      end
    join
    asserts++; if (busy8 !== 1'b0 || lvl8 !== 4'd0) begin failures++; $display("FAIL b2b_end: busy %b level %0d expected 0 0", busy8, lvl8); end
  endtask

  task automatic test_overflow();
    logic [39:0] got;
    int gl, fe;
    bit found;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          din = 32'h1000_0000 + 32'(i);
          din_valid = 1'b1;
          step();
        end
        din_valid = 1'b0;
        asserts++; if (lvl8 !== 4'd8 || ovf8 !== 1'b1) begin failures++; $display("FAIL ovf_after_burst: level %0d overflow %b expected 8 1", lvl8, ovf8); end
      end
      begin
        for (int k = 0; k < 9; k++) begin
          wait_start(1'b0, 20, found);
          asserts++; if (!found) begin failures++; $display("FAIL ovf_start_%0d: no start bit, expected one", k); end
          rx_frame(1'b0, got, gl, fe);
          asserts++; if (got !== {8'hA5, 32'h1000_0000 + 32'(k)} || gl !== 0 || fe !== 0) begin
            failures++; $display("FAIL ovf_frame_%0d: got %h errs %0d/%0d expected %h", k, got, gl, fe, {8'hA5, 32'h1000_0000 + 32'(k)});
          end
        end
      end
    join
    wait_start(1'b0, 40, found);
    asserts++; if (found) begin failures++; $display("FAIL ovf_no_tenth: got a start bit, expected none"); end
    asserts++; if (ovf8 !== 1'b1 || lvl8 !== 4'd0) begin failures++; $display("FAIL ovf_held: overflow %b level %0d expected 1 0", ovf8, lvl8); end
  endtask

  task automatic test_full_pop();
    logic [39:0] got;
    int gl, fe;
    bit found;
    apply_reset();
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          din = 32'h2000_0000 + 32'(i);
          din_valid = 1'b1;
          step();
        end
        din_valid = 1'b0;
      end
      begin
        wait_start(1'b0, 10, found);
        rx_frame(1'b0, got, gl, fe);
        asserts++; if (got !== 40'hA5_2000_0000 || gl !== 0) begin failures++; $display("FAIL fullpop_first: got %h errs %0d expected a520000000 errs 0", got, gl); end
      end
    join
    asserts++; if (lvl8 !== 4'd8 || ovf8 !== 1'b0) begin failures++; $display("FAIL fullpop_pre: level %0d overflow %b expected 8 0", lvl8, ovf8); end
    din = 32'h2000_0009;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    asserts++; if (lvl8 !== 4'd8 || ovf8 !== 1'b0 || tx8 !== 1'b0) begin
      failures++; $display("FAIL fullpop_same_cycle: level %0d overflow %b tx %b expected 8 0 0", lvl8, ovf8, tx8);
    end
    for (int k = 1; k < 10; k++) begin
      wait_start(1'b0, 5, found);
      rx_frame(1'b0, got, gl, fe);
      asserts++; if (!found || got !== {8'hA5, 32'h2000_0000 + 32'(k)} || gl !== 0) begin
        failures++; $display("FAIL fullpop_frame_%0d: found %b got %h errs %0d expected %h", k, found, got, gl, {8'hA5, 32'h2000_0000 + 32'(k)});
      end
    end
    asserts++; if (ovf8 !== 1'b0 || lvl8 !== 4'd0) begin failures++; $display("FAIL fullpop_end: overflow %b level %0d expected 0 0", ovf8, lvl8); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] got;
    int gl, fe;
    bit found;
    apply_reset();
    fork
      begin
        din = 32'h1100_2233;
        din_valid = 1'b1;
        step();
        din = 32'h4455_6677;
        step();
        din_valid = 1'b0;
      end
      begin
        wait_start(1'b0, 10, found);
      end
    join
    repeat (164) step();
    asserts++; if (lvl8 !== 4'd1 || busy8 !== 1'b1) begin failures++; $display("FAIL midreset_pre: level %0d busy %b expected 1 1", lvl8, busy8); end
    reset = 1'b1;
    step();
    asserts++; if (tx8 !== 1'b1 || lvl8 !== 4'd0 || busy8 !== 1'b0 || ovf8 !== 1'b0) begin
      failures++; $display("FAIL midreset_state: tx %b level %0d busy %b overflow %b expected 1 0 0 0", tx8, lvl8, busy8, ovf8);
    end
    reset = 1'b0;
    wait_start(1'b0, 30, found);
    asserts++; if (found) begin failures++; $display("FAIL midreset_discard: got a start bit, expected none"); end
    din = 32'hCAFE_F00D;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    wait_start(1'b0, 5, found);
    rx_frame(1'b0, got, gl, fe);
    asserts++; if (!found || got !== 40'hA5_CAFE_F00D || gl !== 0 || fe !== 0) begin
      failures++; $display("FAIL midreset_new_frame: found %b got %h errs %0d/%0d expected a5cafef00d", found, got, gl, fe);
    end
  endtask

  task automatic test_negative();
    logic [39:0] got8, got16;
    int gl8, fe8, gl16, fe16;
    apply_reset();
    din = 32'hFFFF_FFFE;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    asserts++; if (tx8 !== 1'b0 || tx16 !== 1'b0) begin failures++; $display("FAIL neg_start: tx8 %b tx16 %b expected 0 0", tx8, tx16); end
    fork
      rx_frame(1'b0, got8, gl8, fe8);
      rx_frame(1'b1, got16, gl16, fe16);
    join
    asserts++; if (got8 !== 40'hA5_FFFF_FFFE || gl8 !== 0 || fe8 !== 0) begin
      failures++; $display("FAIL neg_cpb8: got %h errs %0d/%0d expected a5fffffffe errs 0/0", got8, gl8, fe8);
    end
    asserts++; if (got16 !== 40'hA5_FFFF_FFFE || gl16 !== 0 || fe16 !== 0) begin
      failures++; $display("FAIL neg_cpb16: got %h errs %0d/%0d expected a5fffffffe errs 0/0", got16, gl16, fe16);
    end
    asserts++; if (busy16 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL neg_end_busy: busy8 %b busy16 %b expected 0 0", busy8, busy16); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_negative();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
